sensor_timing_gen: RTL and testbench

//  Synthesizable sensor-timing source for the frame buffer input (clk_sensor_pix side): emits o_fval/o_lval/ov_pix_data

---
 rtl/sensor_timing_gen_pkg.sv | 23 ++
 rtl/sensor_timing_gen_test_pattern_gen.sv | 42 ++++
 rtl/sensor_timing_gen.sv | 168 ++++++++++++++++
 tb/tb_sensor_timing_gen.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_timing_gen_pkg.sv
// Shared encodings for the sensor timing source: FSM states, test image selects
// and the minimum length any blanking or porch interval may take.
package sensor_timing_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_HEAD       = 3'd1,
      ST_LINE       = 3'd2,
      ST_LINE_HIDE  = 3'd3,
      ST_TAIL       = 3'd4,
      ST_FRAME_HIDE = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      IMG_PIX_CNT   = 2'd0,
      IMG_LINE_IDX  = 2'd1,
      IMG_COL_IDX   = 2'd2,
      IMG_FRAME_CNT = 2'd3
   } img_sel_t;

   localparam int unsigned GAP_MIN = 1;

endpackage

// File: rtl/sensor_timing_gen_test_pattern_gen.sv
// Test image generator: selects the pixel value for the current position and
// registers it so it lines up with the registered fval/lval of the top.
module test_pattern_gen
   import sensor_timing_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int REG_WD     = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  lval,
   input  logic [1:0]            sel,
   input  logic [REG_WD-1:0]     h_cnt,
   input  logic [REG_WD-1:0]     v_cnt,
   input  logic [DATA_WIDTH-1:0] pix_cnt,
   input  logic [15:0]           frame_cnt,
   output logic [DATA_WIDTH-1:0] pix_data
);

   logic [DATA_WIDTH-1:0] pix_next;

   always_comb begin
      pix_next = '0;
      if (lval) begin
         case (sel)
            IMG_PIX_CNT:   pix_next = pix_cnt;
            IMG_LINE_IDX:  pix_next = DATA_WIDTH'(v_cnt);
            IMG_COL_IDX:   pix_next = DATA_WIDTH'(h_cnt);
            IMG_FRAME_CNT: pix_next = DATA_WIDTH'(frame_cnt);
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_data <= '0;
      end else begin
         pix_data <= pix_next;
      end
   end

endmodule

// File: rtl/sensor_timing_gen.sv
// Programmable sensor timing source: frame/line valid plus a known test image,
// geometry captured once per frame so mid-frame register writes are harmless.
//
// state         | meaning
// --------------+------------------------------------------------------------
// ST_IDLE       | no frame; waits for i_enable with non-zero width/height
// ST_HEAD       | fval high, lval low, before the first line
// ST_LINE       | active pixels of one line, lval high
// ST_LINE_HIDE  | lval low between two lines of the same frame
// ST_TAIL       | fval high, lval low, after the last line
// ST_FRAME_HIDE | fval low; at its end i_enable decides next frame or idle
module sensor_timing_gen
   import sensor_timing_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int REG_WD     = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_enable,
   input  logic [REG_WD-1:0]     iv_width,
   input  logic [REG_WD-1:0]     iv_height,
   input  logic [REG_WD-1:0]     iv_head,
   input  logic [REG_WD-1:0]     iv_tail,
   input  logic [REG_WD-1:0]     iv_line_hide,
   input  logic [REG_WD-1:0]     iv_frame_hide,
   input  logic [1:0]            iv_test_image_sel,
   output logic                  o_fval,
   output logic                  o_lval,
   output logic [DATA_WIDTH-1:0] ov_pix_data,
   output logic [15:0]           ov_frame_cnt
);

   localparam logic [REG_WD-1:0]     ONE_R     = REG_WD'(1);
   localparam logic [REG_WD-1:0]     GAP_MIN_R = REG_WD'(GAP_MIN);
   localparam logic [DATA_WIDTH-1:0] PIX_ONE   = DATA_WIDTH'(1);

   state_t                state;
   logic [REG_WD-1:0]     sh_width;
   logic [REG_WD-1:0]     sh_height;
   logic [REG_WD-1:0]     sh_tail;
   logic [REG_WD-1:0]     sh_line_hide;
   logic [REG_WD-1:0]     sh_frame_hide;
   logic [1:0]            sh_sel;
   logic [REG_WD-1:0]     h_cnt;
   logic [REG_WD-1:0]     v_cnt;
   logic [REG_WD-1:0]     gap_cnt;
   logic [DATA_WIDTH-1:0] pix_cnt;
   logic                  geom_ok;
   logic                  start_frame;
   logic                  fval_s;
   logic                  lval_s;

   function automatic logic [REG_WD-1:0] clamp_gap(input logic [REG_WD-1:0] v);
      return (v < GAP_MIN_R) ? GAP_MIN_R : v;
   endfunction

   assign geom_ok     = i_enable && (iv_width != '0) && (iv_height != '0);
   assign start_frame = geom_ok &&
                        ((state == ST_IDLE) || ((state == ST_FRAME_HIDE) && (gap_cnt == '0)));
   assign fval_s      = (state == ST_HEAD) || (state == ST_LINE) ||
                        (state == ST_LINE_HIDE) || (state == ST_TAIL);
   assign lval_s      = (state == ST_LINE);

   // gap_cnt is a down-counter loaded with length-1 on entry to every porch/blanking state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         sh_width      <= '0;
         sh_height     <= '0;
         sh_tail       <= '0;
         sh_line_hide  <= '0;
         sh_frame_hide <= '0;
         sh_sel        <= '0;
         h_cnt         <= '0;
         v_cnt         <= '0;
         gap_cnt       <= '0;
         pix_cnt       <= '0;
         o_fval        <= 1'b0;
         o_lval        <= 1'b0;
         ov_frame_cnt  <= '0;
      end else begin
         o_fval <= fval_s;
         o_lval <= lval_s;
         if (fval_s && !o_fval)
            ov_frame_cnt <= ov_frame_cnt + 16'd1;

         if (start_frame) begin
            sh_width      <= iv_width;
            sh_height     <= iv_height;
            sh_tail       <= clamp_gap(iv_tail);
            sh_line_hide  <= clamp_gap(iv_line_hide);
            sh_frame_hide <= clamp_gap(iv_frame_hide);
            sh_sel        <= iv_test_image_sel;
            gap_cnt       <= clamp_gap(iv_head) - ONE_R;
            h_cnt         <= '0;
            v_cnt         <= '0;
            pix_cnt       <= '0;
            state         <= ST_HEAD;
         end else begin
            case (state)
               ST_IDLE: begin
               end
               ST_HEAD: begin
                  if (gap_cnt == '0)
                     state <= ST_LINE;
                  else
                     gap_cnt <= gap_cnt - ONE_R;
               end
               ST_LINE: begin
                  pix_cnt <= pix_cnt + PIX_ONE;
                  if (h_cnt == sh_width - ONE_R) begin
                     h_cnt <= '0;
                     if (v_cnt == sh_height - ONE_R) begin
                        state   <= ST_TAIL;
                        gap_cnt <= sh_tail - ONE_R;
                     end else begin
                        state   <= ST_LINE_HIDE;
                        gap_cnt <= sh_line_hide - ONE_R;
                     end
                  end else begin
                     h_cnt <= h_cnt + ONE_R;
                  end
               end
               ST_LINE_HIDE: begin
                  if (gap_cnt == '0) begin
                     state <= ST_LINE;
                     v_cnt <= v_cnt + ONE_R;
                  end else begin
                     gap_cnt <= gap_cnt - ONE_R;
                  end
               end
               ST_TAIL: begin
                  if (gap_cnt == '0) begin
                     state   <= ST_FRAME_HIDE;
                     gap_cnt <= sh_frame_hide - ONE_R;
                  end else begin
                     gap_cnt <= gap_cnt - ONE_R;
                  end
               end
               ST_FRAME_HIDE: begin
                  if (gap_cnt == '0)
                     state <= ST_IDLE;
                  else
                     gap_cnt <= gap_cnt - ONE_R;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   test_pattern_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_WD     (REG_WD)
   ) u_test_pattern_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .lval      (lval_s),
      .sel       (sh_sel),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .pix_cnt   (pix_cnt),
      .frame_cnt (ov_frame_cnt),
      .pix_data  (ov_pix_data)
   );

endmodule

// File: tb/tb_sensor_timing_gen.sv
// Bench for sensor_timing_gen: each frame is compared cycle by cycle against a
// stream built from the geometry, clamp rules and test image definitions.
module tb_sensor_timing_gen;

   logic        clk;
   logic        reset_n;
   logic        i_enable;
   logic [15:0] iv_width;
   logic [15:0] iv_height;
   logic [15:0] iv_head;
   logic [15:0] iv_tail;
   logic [15:0] iv_line_hide;
   logic [15:0] iv_frame_hide;
   logic [1:0]  iv_test_image_sel;
   logic        o_fval;
   logic        o_lval;
   logic [7:0]  ov_pix_data;
   logic [15:0] ov_frame_cnt;

   int checks = 0;
   int errors = 0;
   int exp_frames = 0;

   sensor_timing_gen #(
      .DATA_WIDTH (8),
      .REG_WD     (16)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .i_enable          (i_enable),
      .iv_width          (iv_width),
      .iv_height         (iv_height),
      .iv_head           (iv_head),
      .iv_tail           (iv_tail),
      .iv_line_hide      (iv_line_hide),
      .iv_frame_hide     (iv_frame_hide),
      .iv_test_image_sel (iv_test_image_sel),
      .o_fval            (o_fval),
      .o_lval            (o_lval),
      .ov_pix_data       (ov_pix_data),
      .ov_frame_cnt      (ov_frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_geom(input int w, input int h, input int hd, input int tl,
                           input int lh, input int fh, input int sel);
      iv_width          = 16'(w);
      iv_height         = 16'(h);
      iv_head           = 16'(hd);
      iv_tail           = 16'(tl);
      iv_line_hide      = 16'(lh);
      iv_frame_hide     = 16'(fh);
      iv_test_image_sel = 2'(sel);
   endtask

   // op: 0 none, 1 drop enable, 2 write width=op_val, 3 drop enable and scramble all registers
   task automatic check_frame(input string tag, input int w, input int h, input int hd,
                              input int tl, input int lh, input int fh, input int sel,
                              input int exp_wait, input int op_idx, input int op,
                              input int op_val);
      logic [9:0] exp_q[$];
      logic [9:0] got;
      logic [9:0] first_got;
      logic [9:0] first_exp;
      logic [7:0] d;
      int wt;
      int bad;
      int first_bad;
      int hc, tc, lc, fc, pc;
      hc = (hd < 1) ? 1 : hd;
      tc = (tl < 1) ? 1 : tl;
      lc = (lh < 1) ? 1 : lh;
      fc = (fh < 1) ? 1 : fh;
      wt = 0;
      do begin
         step();
         wt++;
      end while (o_fval !== 1'b1 && wt < 40);
      checks++;
      if (o_fval !== 1'b1) begin
         errors++;
         $display("FAIL %s fval_rise: fval=%b after %0d cycles, required 1", tag, o_fval, wt);
         return;
      end
      if (exp_wait >= 0) begin
         checks++;
         if (wt != exp_wait) begin
            errors++;
            $display("FAIL %s rise_latency: %0d cycles, required %0d", tag, wt, exp_wait);
         end
      end
      exp_frames = (exp_frames + 1) % 65536;
      checks++;
      if (ov_frame_cnt !== 16'(exp_frames)) begin
         errors++;
         $display("FAIL %s frame_cnt: got %0d, required %0d", tag, ov_frame_cnt, exp_frames);
      end

      pc = 0;
      for (int i = 0; i < hc; i++) exp_q.push_back({1'b1, 1'b0, 8'd0});
      for (int l = 0; l < h; l++) begin
         for (int c = 0; c < w; c++) begin
            case (sel)
               0:       d = 8'(pc);
               1:       d = 8'(l);
               2:       d = 8'(c);
               default: d = 8'(exp_frames);
            endcase
            exp_q.push_back({1'b1, 1'b1, d});
            pc++;
         end
         if (l < h - 1)
            for (int i = 0; i < lc; i++) exp_q.push_back({1'b1, 1'b0, 8'd0});
      end
      for (int i = 0; i < tc; i++) exp_q.push_back({1'b1, 1'b0, 8'd0});
      for (int i = 0; i < fc; i++) exp_q.push_back({1'b0, 1'b0, 8'd0});

      bad = 0;
      first_bad = 0;
      first_got = '0;
      first_exp = '0;
      for (int n = 0; n < exp_q.size(); n++) begin
         if (n > 0) step();
         got = {o_fval, o_lval, ov_pix_data};
         if (got !== exp_q[n]) begin
            if (bad == 0) begin
               first_bad = n;
               first_got = got;
               first_exp = exp_q[n];
            end
            bad++;
         end
         if (n == op_idx) begin
            case (op)
               1: i_enable = 1'b0;
               2: iv_width = 16'(op_val);
               3: begin
                  i_enable = 1'b0;
                  set_geom($urandom_range(0, 9), $urandom_range(0, 5), $urandom_range(0, 6),
                           $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                           $urandom_range(0, 3));
               end
               default: ;
            endcase
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s stream: %0d bad cycles, first at %0d got fval/lval/data=%b/%b/%0d required %b/%b/%0d",
                  tag, bad, first_bad, first_got[9], first_got[8], first_got[7:0],
                  first_exp[9], first_exp[8], first_exp[7:0]);
      end
   endtask

   task automatic idle_check(input string tag, input int n);
      int hi;
      hi = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (o_fval !== 1'b0 || o_lval !== 1'b0) hi++;
      end
      checks++;
      if (hi != 0) begin
         errors++;
         $display("FAIL %s idle_fval: %0d cycles with fval/lval high, required 0", tag, hi);
      end
      checks++;
      if (ov_frame_cnt !== 16'(exp_frames)) begin
         errors++;
         $display("FAIL %s idle_frame_cnt: got %0d, required %0d", tag, ov_frame_cnt, exp_frames);
      end
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      i_enable = 1'b0;
      set_geom(4, 2, 2, 2, 3, 5, 2);
      repeat (3) step();
      checks++;
      if (o_fval !== 1'b0) begin errors++; $display("FAIL reset_fval: got %b, required 0", o_fval); end
      checks++;
      if (o_lval !== 1'b0) begin errors++; $display("FAIL reset_lval: got %b, required 0", o_lval); end
      checks++;
      if (ov_pix_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d, required 0", ov_pix_data); end
      checks++;
      if (ov_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d, required 0", ov_frame_cnt); end
      reset_n = 1'b1;
      exp_frames = 0;
      step();
   endtask

   task automatic test_basic();
      set_geom(4, 2, 2, 2, 3, 5, 2);
      i_enable = 1'b1;
      check_frame("basic1", 4, 2, 2, 2, 3, 5, 2, 2, -1, 0, 0);
      check_frame("basic2", 4, 2, 2, 2, 3, 5, 2, 1, 0, 1, 0);
      idle_check("basic", 20);
   endtask

   task automatic test_wrap();
      set_geom(300, 2, 1, 1, 2, 3, 0);
      i_enable = 1'b1;
      check_frame("wrap1", 300, 2, 1, 1, 2, 3, 0, 2, -1, 0, 0);
      check_frame("wrap2", 300, 2, 1, 1, 2, 3, 0, 1, 0, 1, 0);
      idle_check("wrap", 5);
   endtask

   task automatic test_enable_drop();
      set_geom(4, 2, 2, 2, 3, 5, 1);
      i_enable = 1'b1;
      check_frame("drop", 4, 2, 2, 2, 3, 5, 1, 2, 2 + 4 + 3 + 2, 1, 0);
      idle_check("drop", 30);
   endtask

   task automatic test_width_change();
      set_geom(4, 2, 2, 2, 3, 5, 2);
      i_enable = 1'b1;
      check_frame("wchg1", 4, 2, 2, 2, 3, 5, 2, 2, 3, 2, 6);
      check_frame("wchg2", 6, 2, 2, 2, 3, 5, 2, 1, 0, 1, 0);
      idle_check("wchg", 10);
   endtask

   task automatic test_zero_clamp();
      set_geom(3, 2, 0, 0, 0, 0, 3);
      i_enable = 1'b1;
      check_frame("clamp1", 3, 2, 0, 0, 0, 0, 3, 2, -1, 0, 0);
      check_frame("clamp2", 3, 2, 0, 0, 0, 0, 3, 1, 0, 1, 0);
      idle_check("clamp", 10);
   endtask

   task automatic test_reset_mid();
      int k;
      set_geom(8, 3, 2, 2, 2, 2, 0);
      i_enable = 1'b1;
      k = 0;
      do begin
         step();
         k++;
      end while (o_lval !== 1'b1 && k < 50);
      checks++;
      if (o_lval !== 1'b1) begin errors++; $display("FAIL rmid_lval_wait: lval=%b after %0d cycles, required 1", o_lval, k); end
      step();
      step();
      reset_n = 1'b0;
      #1;
      checks++;
      if (o_fval !== 1'b0) begin errors++; $display("FAIL rmid_fval: got %b, required 0", o_fval); end
      checks++;
      if (o_lval !== 1'b0) begin errors++; $display("FAIL rmid_lval: got %b, required 0", o_lval); end
      checks++;
      if (ov_pix_data !== 8'd0) begin errors++; $display("FAIL rmid_data: got %0d, required 0", ov_pix_data); end
      checks++;
      if (ov_frame_cnt !== 16'd0) begin errors++; $display("FAIL rmid_frame_cnt: got %0d, required 0", ov_frame_cnt); end
      exp_frames = 0;
      step();
      step();
      reset_n = 1'b1;
      check_frame("rmid_after", 8, 3, 2, 2, 2, 2, 0, 2, 0, 1, 0);
      idle_check("rmid", 5);
   endtask

   task automatic test_width_zero();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      exp_frames = 0;
      set_geom(0, 2, 1, 1, 1, 1, 2);
      i_enable = 1'b1;
      idle_check("w0", 40);
      set_geom(4, 0, 1, 1, 1, 1, 2);
      idle_check("h0", 20);
      i_enable = 1'b0;
   endtask

   task automatic test_random();
      int w, h, hd, tl, lh, fh, sel;
      for (int it = 0; it < 8; it++) begin
         w   = $urandom_range(1, 12);
         h   = $urandom_range(1, 4);
         hd  = $urandom_range(0, 4);
         tl  = $urandom_range(0, 4);
         lh  = $urandom_range(0, 4);
         fh  = $urandom_range(0, 4);
         sel = $urandom_range(0, 3);
         set_geom(w, h, hd, tl, lh, fh, sel);
         i_enable = 1'b1;
         check_frame("rand", w, h, hd, tl, lh, fh, sel, 2, 1, 3, 0);
      end
      idle_check("rand", 10);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_enable_drop();
      test_width_change();
      test_zero_clamp();
      test_reset_mid();
      test_width_zero();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
